warp_fetcher: RTL and testbench

// - Warp-aware instruction fetcher serving the per-core scheduler; answers the scheduler's fetch stage.
// - Holds one fetch context per warp (2 warps) so a stalled warp's request survives a warp switch.
// - Arbitrates both warps onto a single program-memory read port; reports per-warp status via fetcher_state.

---
 rtl/warp_fetcher_if.sv | 25 ++
 rtl/warp_fetcher.sv | 199 +++++++++++++++++++
 tb/tb_warp_fetcher.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/warp_fetcher_if.sv
// Program-memory read port shared by the warp fetcher (master) and program memory (slave).
// Valid/address are held by the master until the cycle the slave raises ready with data.
interface warp_fetcher_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) ();
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );
endinterface

// File: rtl/warp_fetcher.sv
// Two-warp instruction fetcher: one fetch context per warp arbitrated onto a single program-memory port.
// Optional FETCH_PREFETCH_EN adds a per-warp next-line prefetch slot filled when the port is otherwise idle.
//
// state        | meaning
// CTX_IDLE     | no fetch in progress for this warp
// CTX_FETCHING | waiting for the port / for the memory response
// CTX_FETCHED  | instruction held for the scheduler's decode
module warp_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic                             warp_select,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  warp_fetcher_if.master                   mem
);
  localparam int AW = PROGRAM_MEM_ADDR_BITS;
  localparam int DW = PROGRAM_MEM_DATA_BITS;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    CTX_IDLE     = 3'b000,
    CTX_FETCHING = 3'b001,
    CTX_FETCHED  = 3'b010
  } ctx_state_e;

  ctx_state_e          state_q [2];
  ctx_state_e          state_d [2];
  logic [1:0][AW-1:0]  pc_q, pc_d;
  logic [1:0][DW-1:0]  instr_q, instr_d;
  logic [1:0]          issued_q, issued_d;
  logic                valid_q, valid_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;

  logic                resp;
  logic [1:0]          elig;
  logic                pick;

`ifdef FETCH_PREFETCH_EN
  logic [1:0]          pf_valid_q, pf_valid_d;
  logic [1:0]          pf_want_q, pf_want_d;
  logic [1:0]          pf_issued_q, pf_issued_d;
  logic [1:0][AW-1:0]  pf_pc_q, pf_pc_d;
  logic [1:0][DW-1:0]  pf_instr_q, pf_instr_d;
  logic                req_pf_q, req_pf_d;
`endif

  assign fetcher_state        = state_q[warp_select];
  assign instruction          = instr_q[warp_select];
  assign mem.mem_read_valid   = valid_q;
  assign mem.mem_read_address = addr_q;

  always_comb begin
    for (int i = 0; i < 2; i++) state_d[i] = state_q[i];
    pc_d     = pc_q;
    instr_d  = instr_q;
    issued_d = issued_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    owner_d  = owner_q;
    last_d   = last_q;
    elig     = 2'b00;
    pick     = 1'b0;
    resp     = valid_q & mem.mem_read_ready;
`ifdef FETCH_PREFETCH_EN
    pf_valid_d  = pf_valid_q;
    pf_want_d   = pf_want_q;
    pf_issued_d = pf_issued_q;
    pf_pc_d     = pf_pc_q;
    pf_instr_d  = pf_instr_q;
    req_pf_d    = req_pf_q;
`endif

    // A response whose context was re-targeted meanwhile has issued cleared and is dropped.
    if (resp) begin
      valid_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
      if (req_pf_q) begin
        if (pf_issued_q[owner_q]) begin
          pf_instr_d[owner_q]  = mem.mem_read_data;
          pf_valid_d[owner_q]  = 1'b1;
          pf_issued_d[owner_q] = 1'b0;
        end
      end else
`endif
      if (state_q[owner_q] == CTX_FETCHING && issued_q[owner_q]) begin
        instr_d[owner_q]  = mem.mem_read_data;
        state_d[owner_q]  = CTX_FETCHED;
        issued_d[owner_q] = 1'b0;
        last_d            = owner_q;
`ifdef FETCH_PREFETCH_EN
        pf_pc_d[owner_q]     = pc_q[owner_q] + AW'(1);
        pf_want_d[owner_q]   = 1'b1;
        pf_valid_d[owner_q]  = 1'b0;
        pf_issued_d[owner_q] = 1'b0;
`endif
      end
    end

    unique case (state_d[warp_select])
      CTX_IDLE: begin
        if (core_state == CORE_FETCH) begin
          pc_d[warp_select]     = current_pc;
          state_d[warp_select]  = CTX_FETCHING;
          issued_d[warp_select] = 1'b0;
`ifdef FETCH_PREFETCH_EN
          if (pf_valid_d[warp_select] && pf_pc_d[warp_select] == current_pc) begin
            state_d[warp_select] = CTX_FETCHED;
            instr_d[warp_select] = pf_instr_d[warp_select];
          end
          pf_valid_d[warp_select]  = 1'b0;
          pf_want_d[warp_select]   = 1'b0;
          pf_issued_d[warp_select] = 1'b0;
`endif
        end
      end
      CTX_FETCHING, CTX_FETCHED: begin
        if (core_state == CORE_FETCH && pc_d[warp_select] != current_pc) begin
          pc_d[warp_select]     = current_pc;
          state_d[warp_select]  = CTX_FETCHING;
          issued_d[warp_select] = 1'b0;
        end else if (core_state == CORE_DECODE && state_d[warp_select] == CTX_FETCHED) begin
          state_d[warp_select] = CTX_IDLE;
        end
      end
      default: state_d[warp_select] = CTX_IDLE;
    endcase

    // The port is only reused once valid has dropped, so a new issue never shares the response cycle.
    if (!valid_q) begin
      for (int i = 0; i < 2; i++)
        elig[i] = (state_d[i] == CTX_FETCHING) && !issued_d[i];
      if (elig != 2'b00) begin
        pick           = (elig == 2'b11) ? ~last_q : elig[1];
        valid_d        = 1'b1;
        addr_d         = pc_d[pick];
        issued_d[pick] = 1'b1;
        owner_d        = pick;
`ifdef FETCH_PREFETCH_EN
        req_pf_d       = 1'b0;
      end else if (pf_want_d != 2'b00) begin
        pick              = (pf_want_d == 2'b11) ? ~last_q : pf_want_d[1];
        valid_d           = 1'b1;
        addr_d            = pf_pc_d[pick];
        pf_want_d[pick]   = 1'b0;
        pf_issued_d[pick] = 1'b1;
        owner_d           = pick;
        req_pf_d          = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) state_q[i] <= CTX_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      issued_q <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_valid_q  <= '0;
      pf_want_q   <= '0;
      pf_issued_q <= '0;
      pf_pc_q     <= '0;
      pf_instr_q  <= '0;
      req_pf_q    <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < 2; i++) state_q[i] <= state_d[i];
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      issued_q <= issued_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
`ifdef FETCH_PREFETCH_EN
      pf_valid_q  <= pf_valid_d;
      pf_want_q   <= pf_want_d;
      pf_issued_q <= pf_issued_d;
      pf_pc_q     <= pf_pc_d;
      pf_instr_q  <= pf_instr_d;
      req_pf_q    <= req_pf_d;
`endif
    end
  end
endmodule

// File: tb/tb_warp_fetcher.sv
// Directed bench for warp_fetcher: single fetch, warp switching, arbitration, stale re-fetch, reset.
// Prefetch scenario is compiled only when FETCH_PREFETCH_EN is defined.
module tb_warp_fetcher;
  localparam logic [2:0] C_IDLE   = 3'b000;
  localparam logic [2:0] C_FETCH  = 3'b001;
  localparam logic [2:0] C_DECODE = 3'b010;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic        warp_select;
  logic [7:0]  current_pc;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int vectors = 0;
  int errors  = 0;

  warp_fetcher_if bus ();

  warp_fetcher dut (
    .clk           (clk),
    .reset         (reset),
    .core_state    (core_state),
    .warp_select   (warp_select),
    .current_pc    (current_pc),
    .fetcher_state (fetcher_state),
    .instruction   (instruction),
    .mem           (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [15:0] data);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = data;
    tick();
    bus.mem_read_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; core_state = C_IDLE; warp_select = 1'b0; current_pc = 8'h00;
    bus.mem_read_ready = 1'b0; bus.mem_read_data = 16'h0000;
    tick(); tick();
    vectors++; if (fetcher_state !== 3'b000) begin errors++; $display("FAIL reset_state got %b want 000", fetcher_state); end
    vectors++; if (instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", instruction); end
    vectors++; if (bus.mem_read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.mem_read_valid); end
    vectors++; if (bus.mem_read_address !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", bus.mem_read_address); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_fetch();
    warp_select = 1'b0; current_pc = 8'h05; core_state = C_FETCH;
    tick();
    core_state = C_IDLE;
    vectors++; if (fetcher_state !== 3'b001) begin errors++; $display("FAIL basic_fetching got %b want 001", fetcher_state); end
    vectors++; if (bus.mem_read_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.mem_read_valid); end
    vectors++; if (bus.mem_read_address !== 8'h05) begin errors++; $display("FAIL basic_addr got %h want 05", bus.mem_read_address); end
    tick(); tick();
    vectors++; if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h05) begin errors++;
      $display("FAIL basic_hold got %b/%h want 1/05", bus.mem_read_valid, bus.mem_read_address); end
    respond(16'hA1B2);
    vectors++; if (fetcher_state !== 3'b010) begin errors++; $display("FAIL basic_fetched got %b want 010", fetcher_state); end
    vectors++; if (instruction !== 16'hA1B2) begin errors++; $display("FAIL basic_instr got %h want a1b2", instruction); end
    vectors++; if (bus.mem_read_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", bus.mem_read_valid); end
    core_state = C_DECODE;
    tick();
    core_state = C_IDLE;
    vectors++; if (fetcher_state !== 3'b000) begin errors++; $display("FAIL basic_decode got %b want 000", fetcher_state); end
    vectors++; if (instruction !== 16'hA1B2) begin errors++; $display("FAIL basic_instr_hold got %h want a1b2", instruction); end
  endtask

  task automatic test_warp_switch();
    warp_select = 1'b0; current_pc = 8'h10; core_state = C_FETCH;
    tick();
    warp_select = 1'b1; current_pc = 8'h20; core_state = C_FETCH;
    tick();
    core_state = C_IDLE;
    vectors++; if (fetcher_state !== 3'b001) begin errors++; $display("FAIL switch_w1_state got %b want 001", fetcher_state); end
    vectors++; if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h10) begin errors++;
      $display("FAIL switch_first got %b/%h want 1/10", bus.mem_read_valid, bus.mem_read_address); end
    tick();
    respond(16'h1111);
    vectors++; if (bus.mem_read_valid !== 1'b0) begin errors++; $display("FAIL switch_gap got %b want 0", bus.mem_read_valid); end
    tick();
    vectors++; if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h20) begin errors++;
      $display("FAIL switch_second got %b/%h want 1/20", bus.mem_read_valid, bus.mem_read_address); end
    respond(16'h2222);
    vectors++; if (fetcher_state !== 3'b010 || instruction !== 16'h2222) begin errors++;
      $display("FAIL switch_w1_done got %b/%h want 010/2222", fetcher_state, instruction); end
    warp_select = 1'b0;
    #1;
    vectors++; if (fetcher_state !== 3'b010 || instruction !== 16'h1111) begin errors++;
      $display("FAIL switch_w0_done got %b/%h want 010/1111", fetcher_state, instruction); end
    core_state = C_DECODE; tick();
    warp_select = 1'b1; tick();
    core_state = C_IDLE;
  endtask

  task automatic test_arbitration();
    // leave warp 0 as last served
    warp_select = 1'b0; current_pc = 8'h30; core_state = C_FETCH;
    tick();
    core_state = C_IDLE;
    respond(16'h3030);
    core_state = C_DECODE; tick();
    current_pc = 8'h40; core_state = C_FETCH; tick();
    warp_select = 1'b1; current_pc = 8'h50; tick();
    warp_select = 1'b0; current_pc = 8'h41; tick();
    core_state = C_IDLE;
    respond(16'hDEAD);
    vectors++; if (fetcher_state !== 3'b001) begin errors++; $display("FAIL arb_stale_drop got %b want 001", fetcher_state); end
    tick();
    vectors++; if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h50) begin errors++;
      $display("FAIL arb_w1_first got %b/%h want 1/50", bus.mem_read_valid, bus.mem_read_address); end
    respond(16'h5050);
    tick();
    vectors++; if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h41) begin errors++;
      $display("FAIL arb_w0_next got %b/%h want 1/41", bus.mem_read_valid, bus.mem_read_address); end
    respond(16'h4141);
    vectors++; if (fetcher_state !== 3'b010 || instruction !== 16'h4141) begin errors++;
      $display("FAIL arb_w0_done got %b/%h want 010/4141", fetcher_state, instruction); end
    warp_select = 1'b1;
    #1;
    vectors++; if (instruction !== 16'h5050) begin errors++; $display("FAIL arb_w1_done got %h want 5050", instruction); end
    core_state = C_DECODE; tick();
    warp_select = 1'b0; tick();
    core_state = C_IDLE;
  endtask

  task automatic test_stale_refetch();
    warp_select = 1'b0; current_pc = 8'h08; core_state = C_FETCH;
    tick();
    core_state = C_IDLE;
    respond(16'h0808);
    vectors++; if (fetcher_state !== 3'b010) begin errors++; $display("FAIL stale_first got %b want 010", fetcher_state); end
    current_pc = 8'h09; core_state = C_FETCH;
    tick();
    core_state = C_IDLE;
    vectors++; if (fetcher_state !== 3'b001) begin errors++; $display("FAIL stale_refetch got %b want 001", fetcher_state); end
    vectors++; if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h09) begin errors++;
      $display("FAIL stale_req got %b/%h want 1/09", bus.mem_read_valid, bus.mem_read_address); end
    respond(16'h0909);
    vectors++; if (fetcher_state !== 3'b010 || instruction !== 16'h0909) begin errors++;
      $display("FAIL stale_done got %b/%h want 010/0909", fetcher_state, instruction); end
    core_state = C_DECODE; tick();
    core_state = C_IDLE;
  endtask

  task automatic test_reset_mid_request();
    warp_select = 1'b1; current_pc = 8'h60; core_state = C_FETCH;
    tick();
    core_state = C_IDLE;
    vectors++; if (bus.mem_read_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", bus.mem_read_valid); end
    reset = 1'b0;
    #1;
    vectors++; if (bus.mem_read_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", bus.mem_read_valid); end
    vectors++; if (fetcher_state !== 3'b000) begin errors++; $display("FAIL rst_async_state got %b want 000", fetcher_state); end
    tick();
    reset = 1'b1;
    bus.mem_read_ready = 1'b1; bus.mem_read_data = 16'hBEEF;
    tick(); tick();
    bus.mem_read_ready = 1'b0;
    vectors++; if (fetcher_state !== 3'b000 || instruction !== 16'h0000 || bus.mem_read_valid !== 1'b0) begin errors++;
      $display("FAIL rst_late_ready got %b/%h/%b want 000/0000/0", fetcher_state, instruction, bus.mem_read_valid); end
  endtask

  task automatic test_prefetch();
    warp_select = 1'b0; current_pc = 8'hFF; core_state = C_FETCH;
    tick();
    core_state = C_IDLE;
    vectors++; if (bus.mem_read_address !== 8'hFF) begin errors++; $display("FAIL pf_demand_addr got %h want ff", bus.mem_read_address); end
    respond(16'hF0F0);
    core_state = C_DECODE;
    tick();
    core_state = C_IDLE;
`ifdef FETCH_PREFETCH_EN
    vectors++; if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h00) begin errors++;
      $display("FAIL pf_issue got %b/%h want 1/00", bus.mem_read_valid, bus.mem_read_address); end
    respond(16'h0F0F);
    current_pc = 8'h00; core_state = C_FETCH;
    tick();
    core_state = C_IDLE;
    vectors++; if (fetcher_state !== 3'b010 || instruction !== 16'h0F0F) begin errors++;
      $display("FAIL pf_hit got %b/%h want 010/0f0f", fetcher_state, instruction); end
    vectors++; if (bus.mem_read_valid !== 1'b0) begin errors++; $display("FAIL pf_hit_nomem got %b want 0", bus.mem_read_valid); end
`else
    vectors++; if (bus.mem_read_valid !== 1'b0) begin errors++; $display("FAIL no_prefetch got %b want 0", bus.mem_read_valid); end
    current_pc = 8'h00; core_state = C_FETCH;
    tick();
    core_state = C_IDLE;
    vectors++; if (fetcher_state !== 3'b001 || bus.mem_read_address !== 8'h00 || bus.mem_read_valid !== 1'b1) begin errors++;
      $display("FAIL no_pf_miss got %b/%h/%b want 001/00/1", fetcher_state, bus.mem_read_address, bus.mem_read_valid); end
    respond(16'h0F0F);
`endif
    core_state = C_DECODE; tick();
    core_state = C_IDLE;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_warp_switch();
    test_arbitration();
    test_stale_refetch();
    test_reset_mid_request();
    test_prefetch();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
